multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle main control state machine for the RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALUOp code consumed by the ALU control decoder, plus the datapath enables. It sits between the instruction register and memory handshake on one side and the PC, register file, ALU operand muxes and memory port on the other.

## Interface
Parameters:
- none

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- run  input  1  leave IDLE and begin fetching; sampled only in IDLE
- opcode  input  7  instruction register bits [6:0]; valid from DECODE onward
- fun3  input  3  instruction register bits [14:12]
- alu_zero  input  1  ALU result == 0, valid in BRANCH
- alu_lt  input  1  signed less-than from ALU subtract, valid in BRANCH
- mem_ready  input  1  memory completes the pending request this cycle
- mem_req  output  1  memory request active
- mem_we  output  1  request is a write (qualified by mem_req)
- ir_write  output  1  load instruction register
- pc_write  output  1  PC <= PC+4 this cycle
- pc_branch  output  1  PC <= branch target this cycle
- alu_op  output  2  00 add, 01 branch compare, 10 R/I function decode
- alu_fun7_en  output  1  pass instruction bit 30 to ALU control; else forced 0
- alu_src_b_imm  output  1  ALU operand B = immediate (else rs2)
- reg_write  output  1  register file write enable
- mem_to_reg  output  1  writeback data from memory (else ALU)
- busy  output  1  state != IDLE
- illegal_instr  output  1  trap flag (see Configuration)

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP.
- All outputs are Moore, decoded from state (plus fun3/alu flags in BRANCH). In any state not listed for an output, that output is 0.
- IDLE: all outputs 0. If run=1, go to FETCH.
- FETCH: mem_req=1, mem_we=0. Hold until mem_ready=1. On that cycle ir_write=1 and pc_write=1, then go to DECODE.
- DECODE: no enables. Dispatch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - other -> TRAP or FETCH, per Configuration.
- EXEC_R: alu_op=10, alu_fun7_en=1, alu_src_b_imm=0. Go to WB_ALU.
- EXEC_I: alu_op=10, alu_src_b_imm=1, alu_fun7_en=1 only when fun3=101 (SRLI/SRAI). Go to WB_ALU.
- MEM_ADDR: alu_op=00, alu_src_b_imm=1. Go to MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: alu_op=00, alu_src_b_imm=1, mem_req=1. Hold until mem_ready, then go to WB_MEM.
- MEM_WR: alu_op=00, alu_src_b_imm=1, mem_req=1, mem_we=1. Hold until mem_ready, then go to FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0, alu_op and mux selects held from the EXEC state. Go to FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1. Go to FETCH.
- BRANCH: alu_op=01, alu_src_b_imm=0. pc_branch = taken, where taken by fun3 is:
  - 000: alu_zero
  - 001: !alu_zero
  - 100: alu_lt
  - 101: !alu_lt
  - other fun3 -> not taken; with the macro, go to TRAP instead.
  - Go to FETCH.
- pc_write and pc_branch are never asserted together.

## Timing
- Reset (asynchronous assert): state=IDLE immediately, all outputs 0 while rst_n=0.
- Reset mid-request: mem_req drops asynchronously. No completion is reported, and the interrupted instruction is discarded.
- Cycle counts with zero-wait memory (mem_ready high in the first request cycle), FETCH to next FETCH:
  - R/I: 4
  - load: 5
  - store: 4
  - branch: 3
- Each wait cycle adds one cycle. Outputs stay stable while waiting.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- run is ignored outside IDLE. The machine never returns to IDLE except through reset.

## Configuration
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE, or an unsupported branch fun3 in BRANCH, goes to TRAP.
  - TRAP holds illegal_instr=1 and busy=1 with all other outputs 0, until reset.
- Undefined:
  - Unknown opcode is treated as NOP (DECODE -> FETCH).
  - Unsupported branch fun3 is not taken.
  - The TRAP state is not built and illegal_instr is tied 0.

## Test plan
- Reset/start: rst_n=0 with run=1 -> all outputs 0. Release, run=1 -> FETCH asserts mem_req=1 on the next cycle.
- ADD (opcode 0110011), zero-wait memory -> ir_write/pc_write in cycle 1, alu_op=10 with alu_fun7_en=1 in cycle 3, reg_write=1 in cycle 4, FETCH again in cycle 5.
- LW with 3 wait cycles in MEM_RD -> mem_req held 4 cycles, mem_we=0, then WB_MEM with mem_to_reg=1 and reg_write=1.
- BNE (fun3=001): alu_zero=0 -> pc_branch=1; repeat with alu_zero=1 -> pc_branch=0. Both return to FETCH after 3 cycles.
- ADDI vs SRAI: fun3=000 -> alu_fun7_en=0; fun3=101 -> alu_fun7_en=1, alu_src_b_imm=1.
- Opcode 1111111:
  - with ILLEGAL_TRAP_EN -> illegal_instr=1, held until rst_n=0.
  - without -> FETCH follows DECODE and illegal_instr stays 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-unit handshake bundle: instruction/ALU status and memory ready in,
// datapath enables and memory request out. master = control unit side.
interface multicycle_control_if;
  logic       run;
  logic [6:0] opcode;
  logic [2:0] fun3;
  logic       alu_zero;
  logic       alu_lt;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic       pc_branch;
  logic [1:0] alu_op;
  logic       alu_fun7_en;
  logic       alu_src_b_imm;
  logic       reg_write;
  logic       mem_to_reg;
  logic       busy;
  logic       illegal_instr;

  modport master (
    input  run, opcode, fun3, alu_zero, alu_lt, mem_ready,
    output mem_req, mem_we, ir_write, pc_write, pc_branch, alu_op,
           alu_fun7_en, alu_src_b_imm, reg_write, mem_to_reg, busy, illegal_instr
  );

  modport slave (
    output run, opcode, fun3, alu_zero, alu_lt, mem_ready,
    input  mem_req, mem_we, ir_write, pc_write, pc_branch, alu_op,
           alu_fun7_en, alu_src_b_imm, reg_write, mem_to_reg, busy, illegal_instr
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V main control FSM (fetch/decode/exec/mem/writeback).
// Define ILLEGAL_TRAP_EN to build the TRAP state for bad opcodes / branch fun3.
module multicycle_control (
  input logic            clk,
  input logic            rst_n,
  multicycle_control_if.master bus
);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] alu_op;
    logic       fun7_en;
    logic       src_b_imm;
    logic       reg_write;
    logic       mem_to_reg;
    logic       busy;
  } ctl_t;

  state_t state, nst;
  ctl_t   ctl;
  logic   taken, f3_ok;

  always_comb begin
    taken = 1'b0;
    f3_ok = 1'b1;
    case (bus.fun3)
      3'b000:  taken = bus.alu_zero;
      3'b001:  taken = !bus.alu_zero;
      3'b100:  taken = bus.alu_lt;
      3'b101:  taken = !bus.alu_lt;
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    nst = state;
    case (state)
      IDLE:   if (bus.run) nst = FETCH;
      FETCH:  if (bus.mem_ready) nst = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_R:         nst = EXEC_R;
          OP_I:         nst = EXEC_I;
          OP_LD, OP_ST: nst = MEM_ADDR;
          OP_BR:        nst = BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:      nst = TRAP;
`else
          default:      nst = FETCH;
`endif
        endcase
      end
      EXEC_R, EXEC_I: nst = WB_ALU;
      MEM_ADDR:       nst = (bus.opcode == OP_LD) ? MEM_RD : MEM_WR;
      MEM_RD:         if (bus.mem_ready) nst = WB_MEM;
      MEM_WR:         if (bus.mem_ready) nst = FETCH;
      WB_ALU, WB_MEM: nst = FETCH;
`ifdef ILLEGAL_TRAP_EN
      BRANCH:         nst = f3_ok ? FETCH : TRAP;
      TRAP:           nst = TRAP;
`else
      BRANCH:         nst = FETCH;
`endif
      default:        nst = IDLE;
    endcase
  end

  // Moore outputs for the state being entered; the IR is stable across an
  // instruction, so opcode/fun3 can steer WB_ALU to repeat its EXEC selects.
  function automatic ctl_t decode(state_t s, logic is_r, logic f3_sr);
    ctl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      FETCH:    c.mem_req = 1'b1;
      EXEC_R:   begin c.alu_op = 2'b10; c.fun7_en = 1'b1; end
      EXEC_I:   begin c.alu_op = 2'b10; c.src_b_imm = 1'b1; c.fun7_en = f3_sr; end
      WB_ALU:   begin
        c.alu_op    = 2'b10;
        c.reg_write = 1'b1;
        c.src_b_imm = !is_r;
        c.fun7_en   = is_r | f3_sr;
      end
      MEM_ADDR: c.src_b_imm = 1'b1;
      MEM_RD:   begin c.src_b_imm = 1'b1; c.mem_req = 1'b1; end
      MEM_WR:   begin c.src_b_imm = 1'b1; c.mem_req = 1'b1; c.mem_we = 1'b1; end
      WB_MEM:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      BRANCH:   c.alu_op = 2'b01;
      default:  ;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctl   <= '0;
    end else begin
      state <= nst;
      ctl   <= decode(nst, bus.opcode[5], bus.fun3 == 3'b101);
    end
  end

  assign bus.mem_req       = ctl.mem_req;
  assign bus.mem_we        = ctl.mem_we;
  assign bus.alu_op        = ctl.alu_op;
  assign bus.alu_fun7_en   = ctl.fun7_en;
  assign bus.alu_src_b_imm = ctl.src_b_imm;
  assign bus.reg_write     = ctl.reg_write;
  assign bus.mem_to_reg    = ctl.mem_to_reg;
  assign bus.busy          = ctl.busy;

  // Completion-qualified strobes depend on same-cycle handshake / ALU flags.
  assign bus.ir_write  = (state == FETCH) && bus.mem_ready;
  assign bus.pc_write  = (state == FETCH) && bus.mem_ready;
  assign bus.pc_branch = (state == BRANCH) && taken;

`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_instr = (state == TRAP);
`else
  assign bus.illegal_instr = 1'b0;
`endif
endmodule
